// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC and buffers up to two fetched
// instructions for decode behind a valid/ready handshake. Optional macro: FETCH_FAULT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_01FC
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] PC,
  input  logic [31:0] Instr,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD,
  input  logic        ReadyD,
  output logic        FetchFault
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // The fault range check compares word addresses, so the limit must be word aligned.
  if (IMEM_LIMIT[1:0] != 2'b00) begin : g_limit_check
    $error("IMEM_LIMIT must be word aligned");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  fetch_entry_t     head_q, head_d;
  fetch_entry_t     tail_q, tail_d;
  fetch_entry_t     new_entry;
  logic [XLEN-1:0]  target_aligned;
  logic             pop, room, fetch_ok, push;
  logic             out_of_range, fault_hold;
  logic             unused_tgt_bits;

  assign unused_tgt_bits = ^BranchTarget[1:0];
  assign target_aligned  = {BranchTarget[XLEN-1:2], 2'b00};
  assign new_entry       = '{instr: Instr, pc: pc_q};

`ifdef FETCH_FAULT_EN
  logic fault_q, fault_d;
  assign out_of_range = (pc_q > IMEM_LIMIT);
  assign fault_hold   = fault_q;
  assign FetchFault   = fault_q;
`else
  assign out_of_range = 1'b0;
  assign fault_hold   = 1'b0;
  assign FetchFault   = 1'b0;
`endif

  // Handshake and buffer next-state; head_q is always the oldest entry.
  always_comb begin
    count_d  = count_q;
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    pop      = (count_q != CNT_W'(0)) & ReadyD;
    room     = (count_q < CNT_W'(2)) | pop;
    fetch_ok = ~BranchTaken & ~fault_hold & room;
    push     = fetch_ok & ~out_of_range;
`ifdef FETCH_FAULT_EN
    fault_d  = fault_q;
`endif

    if (BranchTaken) begin
      // Redirect discards everything, including an entry handshaked this cycle.
      count_d = CNT_W'(0);
      pc_d    = target_aligned;
`ifdef FETCH_FAULT_EN
      fault_d = fault_q & (target_aligned > IMEM_LIMIT);
`endif
    end else begin
`ifdef FETCH_FAULT_EN
      if (fetch_ok && out_of_range) fault_d = 1'b1;
`endif
      if (push) pc_d = pc_q + XLEN'(4);
      case ({push, pop})
        2'b10: begin
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(0)) head_d = new_entry;
          else                      tail_d = new_entry;
        end
        2'b01: begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(2)) head_d = tail_q;
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            head_d = new_entry;
          end else begin
            head_d = tail_q;
            tail_d = new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_q <= CNT_W'(0);
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
`ifdef FETCH_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
`ifdef FETCH_FAULT_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign PC       = pc_q;
  assign ValidD   = (count_q != CNT_W'(0));
  assign InstrD   = head_q.instr;
  assign PCD      = head_q.pc;
  assign PCPlus8D = head_q.pc + XLEN'(8);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] IMEM_LIMIT = 32'h0000_01FC;
`ifdef FETCH_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_d, pc_d, pc_plus8_d;
  logic        valid_d, ready_d, fetch_fault;

  logic [31:0] mem [0:127];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  ent_t        mq[$];
  ent_t        m_last;
  logic [31:0] m_pc;
  bit          m_fault;

  fetch_stage #(.RESET_PC(RESET_PC), .IMEM_LIMIT(IMEM_LIMIT)) dut (
    .CLK(clk), .Reset(reset), .PC(pc), .Instr(instr),
    .BranchTaken(branch_taken), .BranchTarget(branch_target),
    .InstrD(instr_d), .PCD(pc_d), .PCPlus8D(pc_plus8_d),
    .ValidD(valid_d), .ReadyD(ready_d), .FetchFault(fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [6:0] idx;
    idx = a[8:2];
    if (a <= IMEM_LIMIT) return mem[idx];
    return 32'h0;
  endfunction

  always_comb instr = mem_read(pc);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock of the reference model, from the behavioural rules.
  task automatic model_step(input bit r, input bit br, input logic [31:0] tgt, input bit rdy);
    bit popped, room;
    logic [31:0] tal;
    if (r) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
      m_last  = '0;
      return;
    end
    popped = (mq.size() != 0) && rdy;
    room   = (mq.size() < 2) || popped;
    tal    = tgt & 32'hFFFF_FFFC;
    if (br) begin
      mq.delete();
      m_pc = tal;
      if (tal <= IMEM_LIMIT) m_fault = 1'b0;
    end else begin
      if (popped) void'(mq.pop_front());
      if (!m_fault && room) begin
        if (FAULT_EN && m_pc > IMEM_LIMIT) m_fault = 1'b1;
        else begin
          mq.push_back('{instr: mem_read(m_pc), pc: m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    if (mq.size() != 0) m_last = mq[0];
  endtask

  task automatic check_outputs();
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : m_last;
    chk("pc", pc, m_pc);
    chk("valid_d", {31'h0, valid_d}, {31'h0, mq.size() != 0});
    chk("instr_d", instr_d, h.instr);
    chk("pc_d", pc_d, h.pc);
    chk("pc_plus8_d", pc_plus8_d, h.pc + 32'd8);
    chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, FAULT_EN && m_fault});
  endtask

  task automatic tick(input bit r, input bit br, input logic [31:0] tgt, input bit rdy);
    @(negedge clk);
    reset = r; branch_taken = br; branch_target = tgt; ready_d = rdy;
    model_step(r, br, tgt, rdy);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  logic [31:0] exp_pcd [0:3];
  logic [31:0] exp_ins [0:3];

  initial begin
    reset = 1'b1; branch_taken = 1'b0; branch_target = '0; ready_d = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0] = 32'hE200_0000; mem[1] = 32'hE590_0001;
    mem[2] = 32'hE590_0001; mem[3] = 32'hE0E0_2000;
    exp_pcd[0] = 32'h0; exp_pcd[1] = 32'h4; exp_pcd[2] = 32'h8; exp_pcd[3] = 32'hC;
    exp_ins[0] = 32'hE200_0000; exp_ins[1] = 32'hE590_0001;
    exp_ins[2] = 32'hE590_0001; exp_ins[3] = 32'hE0E0_2000;

    // Reset state
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'h0, valid_d}, 32'h0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_pcd", pc_d, 32'h0);
    chk("rst_pc8", pc_plus8_d, 32'h8);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);

    // Streaming at one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 1);
      chk("stream_valid", {31'h0, valid_d}, 32'h1);
      chk("stream_pcd", pc_d, exp_pcd[i]);
      chk("stream_instr", instr_d, exp_ins[i]);
      chk("stream_pc8", pc_plus8_d, exp_pcd[i] + 32'd8);
    end

    // Stall fills the buffer, then drains with no gap or duplicate
    tick(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
    chk("stall_pc", pc, 32'h8);
    chk("stall_pcd", pc_d, 32'h0);
    chk("stall_instr", instr_d, 32'hE200_0000);
    for (int i = 1; i < 4; i++) begin
      tick(0, 0, 0, 1);
      chk("drain_pcd", pc_d, exp_pcd[i]);
    end

    // Redirect while full
    tick(0, 1, 32'h23, 0);
    chk("redir_valid", {31'h0, valid_d}, 32'h0);
    chk("redir_pc", pc, 32'h20);
    tick(0, 0, 0, 0);
    chk("redir_valid2", {31'h0, valid_d}, 32'h1);
    chk("redir_pcd", pc_d, 32'h20);
    chk("redir_pc2", pc, 32'h24);

    // Reset beats redirect
    tick(1, 1, 32'h40, 1);
    chk("rstbr_pc", pc, 32'h0);
    chk("rstbr_valid", {31'h0, valid_d}, 32'h0);

    // Fetch past the end of instruction memory
    tick(0, 1, 32'h1F8, 1);
    tick(0, 0, 0, 1);
    chk("edge_pcd0", pc_d, 32'h1F8);
    tick(0, 0, 0, 1);
    chk("edge_pcd1", pc_d, 32'h1FC);
    chk("edge_pc", pc, 32'h200);
    tick(0, 0, 0, 1);
    if (FAULT_EN) begin
      chk("fault_flag", {31'h0, fetch_fault}, 32'h1);
      chk("fault_valid", {31'h0, valid_d}, 32'h0);
      chk("fault_pc", pc, 32'h200);
    end else begin
      chk("nofault_flag", {31'h0, fetch_fault}, 32'h0);
      chk("nofault_pcd", pc_d, 32'h200);
      chk("nofault_instr", instr_d, 32'h0);
    end
    tick(0, 0, 0, 1);
    if (FAULT_EN) chk("fault_pc_hold", pc, 32'h200);
    tick(0, 1, 32'h0, 1);
    chk("clr_fault", {31'h0, fetch_fault}, 32'h0);
    tick(0, 0, 0, 1);
    chk("clr_pcd", pc_d, 32'h0);
    chk("clr_valid", {31'h0, valid_d}, 32'h1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, br, rdy;
      logic [31:0] t;
      r   = ($urandom_range(99) == 0);
      br  = ($urandom_range(15) == 0);
      rdy = ($urandom_range(3) != 0);
      case ($urandom_range(9))
        0:       t = $urandom;
        1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        default: t = 32'($urandom_range(32'h230));
      endcase
      tick(r, br, t, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end for the single-issue ARM-subset core.
- Owns the fetch PC and drives it to InstrMem's PC input, then captures the returned Instr into a 2-entry fetch buffer.
- Presents instructions to the decode stage over a valid/ready handshake.
- Absorbs decode stalls without refetching, and flushes on branch redirects from execute.

Parameters:
- RESET_PC, 32'h00000000, fetch address loaded on reset.
- IMEM_LIMIT, 32'h000001FC, highest valid word address of InstrMem (128 words).

Ports:
- CLK  input  1  core clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- PC  output  32  fetch address to InstrMem.
- Instr  input  32  combinational InstrMem read data for PC.
- BranchTaken  input  1  redirect request from execute.
- BranchTarget  input  32  redirect address; bits [1:0] ignored.
- InstrD  output  32  head-of-buffer instruction to decode.
- PCD  output  32  address of InstrD.
- PCPlus8D  output  32  PCD+8 (ARM R15 read value).
- ValidD  output  1  InstrD/PCD valid.
- ReadyD  input  1  decode accepts the head entry this cycle.
- FetchFault  output  1  sticky out-of-range fetch flag (see Optional Feature).

Behaviour:
- Reset (Reset=1 at edge):
  - PC_F<=RESET_PC and Count<=0.
  - Fault state cleared.
  - Outputs after reset: PC=RESET_PC, ValidD=0, InstrD=0, PCD=0, PCPlus8D=8, FetchFault=0.
- Reset has priority over every other input. Reset mid-operation discards all buffered entries.
- PC output is PC_F, combinational from the register. Instr is sampled in the same cycle.
- Pop: Pop = ValidD & ReadyD.
- Push condition: Push = ~BranchTaken & ~FaultHold & (Count<2 | Pop).
- On Push:
  - The entry {Instr, PC_F} is written at the tail.
  - PC_F<=PC_F+4, wrapping modulo 2^32; the wrap from 32'hFFFFFFFC to 0 is legal.
- Count update:
  - Count +1 on Push only, −1 on Pop only.
  - Unchanged when Push and Pop occur together, or when neither occurs.
  - Never exceeds 2.
- Head and outputs:
  - Head is the oldest entry. ValidD = (Count!=0).
  - InstrD/PCD show the head entry. When Count=0, they hold their last value.
  - PCPlus8D = PCD+8, combinational.
- Buffer full (Count=2, ReadyD=0):
  - No push; PC_F holds.
  - InstrD/PCD stay stable until accepted.
- Buffer empty: ValidD=0, and ReadyD is ignored.
- Latency:
  - First instruction is valid one cycle after Reset deasserts.
  - Steady-state throughput is 1 instruction/cycle while ReadyD=1.
- Redirect (BranchTaken=1 at edge):
  - Count<=0; all entries are discarded, including an entry popped in the same cycle.
  - PC_F<={BranchTarget[31:2],2'b00}.
  - No push that cycle.
  - The target instruction is valid on ValidD the next cycle.
  - Decode must flush its own copy of any instruction handshaked in the redirect cycle.
- Redirect while buffer full or stalled: same as above; the redirect always wins over the stall.

Optional Feature:
- Macro: FETCH_FAULT_EN.
- Defined:
  - If PC_F > IMEM_LIMIT in a cycle where a push would occur, no push happens.
  - FaultHold<=1 and FetchFault<=1. FetchFault is sticky and PC_F holds.
  - Buffered entries still drain to decode.
  - Cleared only by Reset, or by a redirect whose target is ≤ IMEM_LIMIT; a redirect to an out-of-range target re-faults next cycle.
- Not defined:
  - FaultHold=0 and FetchFault is tied 0.
  - Out-of-range fetches proceed normally and push whatever Instr returns (InstrMem returns 0).

Test Plan:
- Reset, then ReadyD=1 for 4 cycles with InstrMem preloaded (E2000000, E5900001, E5900001, E0E02000, …) → ValidD=1 from cycle 1. PCD=0,4,8,C in successive cycles; InstrD matches; PCPlus8D=8,C,10,14.
- ReadyD=0 for 5 cycles starting at PCD=0 → Count saturates at 2, PC_F holds at 8, InstrD stays E2000000. On ReadyD=1: PCD=0,4,8 with no gap and no duplicate.
- BranchTaken=1 with BranchTarget=32'h00000023 while Count=2 → next cycle ValidD=1, PCD=32'h20, PC=32'h24, and old entries 0 and 4 are never presented.
- BranchTaken=1 together with Reset=1 → PC=RESET_PC, ValidD=0 next cycle (reset wins).
- With FETCH_FAULT_EN, redirect to 32'h1F8 with ReadyD=1 → PCD=1F8, then 1FC. At PC_F=200 FetchFault=1, ValidD drops after draining, and PC stays 200. A redirect to 0 clears FetchFault and PCD=0 next cycle.
- Without FETCH_FAULT_EN, same stimulus → FetchFault=0 throughout, PCD=200 presented with InstrD=0.
